// File: rtl/btn_event_detector.sv
// Push-button front end: synchronizes and debounces a raw button, then classifies
// press / release / long-press events. Define BTN_AUTOREPEAT_EN to add auto-repeat while held.
module btn_event_detector #(
  parameter int DEBOUNCE_COUNT_THRESHOLD = 300,
  parameter int LONG_PRESS_CYCLES        = 1000,
  parameter int REPEAT_CYCLES            = 200
) (
  input  logic sysclk,
  input  logic reset,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse,
  output logic btn_state
);

  localparam int DEB_W  = $clog2(DEBOUNCE_COUNT_THRESHOLD + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_COUNT_THRESHOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  if (DEBOUNCE_COUNT_THRESHOLD < 1 || LONG_PRESS_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("btn_event_detector: all cycle-count parameters must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  logic              sync1_q,     sync1_d;
  logic              sync_btn_q,  sync_btn_d;
  logic [DEB_W-1:0]  deb_cnt_q,   deb_cnt_d;
  logic              btn_state_q, btn_state_d;
  state_t            state_q,     state_d;
  logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
  logic              press_q,     press_d;
  logic              release_q,   release_d;
  logic              long_q,      long_d;
  logic              accept_press;
  logic              accept_release;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
  logic [REP_W-1:0]  rep_cnt_q,   rep_cnt_d;
`endif

  // NOTE: every signal assigned in this block gets a default first, so no path
  // through the if/case tree can leave one unassigned and infer a latch.
  always_comb begin
    sync1_d        = btn;
    sync_btn_d     = sync1_q;

    // Any sample matching the debounced level drops all accumulated credit.
    deb_cnt_d      = '0;
    btn_state_d    = btn_state_q;
    accept_press   = 1'b0;
    accept_release = 1'b0;
    if (sync_btn_q != btn_state_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_state_d    = sync_btn_q;
        accept_press   = sync_btn_q;
        accept_release = ~sync_btn_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end

    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept_press) begin
          state_d    = PRESSED;
          hold_cnt_d = '0;
          press_d    = 1'b1;
        end
      end
      PRESSED: begin
        // A release on the threshold edge wins: the long press never happened.
        if (accept_release) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      HELD: begin
        if (accept_release) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end
`ifdef BTN_AUTOREPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
          press_d   = 1'b1;
        end else begin
          rep_cnt_d = rep_cnt_q + REP_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      sync1_q     <= 1'b0;
      sync_btn_q  <= 1'b0;
      deb_cnt_q   <= '0;
      btn_state_q <= 1'b0;
      state_q     <= IDLE;
      hold_cnt_q  <= '0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      sync1_q     <= sync1_d;
      sync_btn_q  <= sync_btn_d;
      deb_cnt_q   <= deb_cnt_d;
      btn_state_q <= btn_state_d;
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign press_pulse      = press_q;
  assign release_pulse    = release_q;
  assign long_press_pulse = long_q;
  assign btn_state        = btn_state_q;

endmodule

// File: tb/tb_btn_event_detector.sv
// Directed bench for btn_event_detector (THRESHOLD=4, LONG=20, REPEAT=5); pulse
// cycle numbers are logged and compared against hand-computed edge counts.
module tb_btn_event_detector;

  localparam int T = 4;
  localparam int L = 20;
  localparam int R = 5;

  logic sysclk = 1'b0;
  logic reset;
  logic btn;
  logic press_pulse, release_pulse, long_press_pulse, btn_state;

  btn_event_detector #(
    .DEBOUNCE_COUNT_THRESHOLD(T),
    .LONG_PRESS_CYCLES       (L),
    .REPEAT_CYCLES           (R)
  ) dut (
    .sysclk          (sysclk),
    .reset           (reset),
    .btn             (btn),
    .press_pulse     (press_pulse),
    .release_pulse   (release_pulse),
    .long_press_pulse(long_press_pulse),
    .btn_state       (btn_state)
  );

  always #5 sysclk = ~sysclk;

  // cyc = number of rising edges so far; pulses are logged with the edge that launched them.
  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int press_log[$];
  int rel_log[$];
  int long_log[$];
  int both_cnt = 0;

  always @(negedge sysclk) begin
    if (press_pulse)                  press_log.push_back(cyc);
    if (release_pulse)                rel_log.push_back(cyc);
    if (long_press_pulse)             long_log.push_back(cyc);
    if (press_pulse && release_pulse) both_cnt++;
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_logs();
    press_log.delete();
    rel_log.delete();
    long_log.delete();
  endtask

  task automatic start(input logic v, output int t0);
    @(negedge sysclk);
    t0  = cyc;
    btn = v;
  endtask

  task automatic drive(input logic v, input int n);
    repeat (n) begin
      @(negedge sysclk);
      btn = v;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int t0, t1, r;
  int seq[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};

  initial begin
    reset = 1'b1;
    btn   = 1'b0;
    repeat (3) @(negedge sysclk);
    check("rst_press",   int'(press_pulse),      0);
    check("rst_release", int'(release_pulse),    0);
    check("rst_long",    int'(long_press_pulse), 0);
    check("rst_state",   int'(btn_state),        0);
    reset = 1'b0;
    drive(1'b0, 4);

    // Clean press then clean release.
    clear_logs();
    start(1'b1, t0);
    drive(1'b1, 9);
    check("clean_press_n",  press_log.size(), 1);
    check("clean_press_t",  q_at(press_log, 0), t0 + 6);
    check("clean_state_hi", int'(btn_state), 1);
    start(1'b0, t1);
    drive(1'b0, 9);
    check("clean_rel_n",    rel_log.size(), 1);
    check("clean_rel_t",    q_at(rel_log, 0), t1 + 6);
    check("clean_state_lo", int'(btn_state), 0);
    check("clean_long_n",   long_log.size(), 0);
    check("clean_press_n2", press_log.size(), 1);

    // Bouncy press: only the final run of four high samples counts.
    clear_logs();
    start(seq[0][0], t0);
    for (int i = 1; i < 9; i++) drive(seq[i][0], 1);
    drive(1'b1, 6);
    check("bounce_press_n", press_log.size(), 1);
    check("bounce_press_t", q_at(press_log, 0), t0 + 11);
    check("bounce_state",   int'(btn_state), 1);
    drive(1'b0, 12);
    clear_logs();

    // Long press held 40 cycles; repeats (when enabled) every 5 after long press,
    // the one that would land on the release edge is suppressed.
    start(1'b1, t0);
    drive(1'b1, 39);
    start(1'b0, t1);
    drive(1'b0, 11);
    check("long_press_t0", q_at(press_log, 0), t0 + 6);
    check("long_n",        long_log.size(), 1);
    check("long_t",        q_at(long_log, 0), t0 + 26);
    check("long_rel_n",    rel_log.size(), 1);
    check("long_rel_t",    q_at(rel_log, 0), t1 + 6);
`ifdef BTN_AUTOREPEAT_EN
    check("long_press_n",  press_log.size(), 4);
    check("repeat1_t",     q_at(press_log, 1), t0 + 31);
    check("repeat2_t",     q_at(press_log, 2), t0 + 36);
    check("repeat3_t",     q_at(press_log, 3), t0 + 41);
`else
    check("long_press_n",  press_log.size(), 1);
`endif

    // Release accepted on the very edge where hold_cnt==19.
    clear_logs();
    start(1'b1, t0);
    drive(1'b1, 19);
    start(1'b0, t1);
    drive(1'b0, 29);
    check("race_press_n", press_log.size(), 1);
    check("race_press_t", q_at(press_log, 0), t0 + 6);
    check("race_rel_n",   rel_log.size(), 1);
    check("race_rel_t",   q_at(rel_log, 0), t0 + 26);
    check("race_long_n",  long_log.size(), 0);
    check("race_state",   int'(btn_state), 0);
    check("race_fsm",     int'(dut.state_q), 0);

    // Reset mid-press (hold_cnt=10) with the button still held afterwards.
    clear_logs();
    start(1'b1, t0);
    drive(1'b1, 16);
    reset = 1'b1;
    #1;
    check("midrst_press", int'(press_pulse),      0);
    check("midrst_rel",   int'(release_pulse),    0);
    check("midrst_long",  int'(long_press_pulse), 0);
    check("midrst_state", int'(btn_state),        0);
    clear_logs();
    drive(1'b1, 2);
    reset = 1'b0;
    r = cyc;
    drive(1'b1, 30);
    check("after_rst_press_n", press_log.size(), 1);
    check("after_rst_press_t", q_at(press_log, 0), r + 6);
    check("after_rst_rel_n",   rel_log.size(), 0);
    check("after_rst_long_t",  q_at(long_log, 0), r + 26);
    drive(1'b0, 12);
    check("after_rst_rel_final", rel_log.size(), 1);

    check("press_and_release_same_cycle", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/btn_event_detector.md
BTN_EVENT_DETECTOR -- requirements
Module: btn_event_detector

Interface
REQ-001 SHALL have parameter DEBOUNCE_COUNT_THRESHOLD, default 300, meaning consecutive sysclk cycles of changed synchronized input needed to accept a new level; legal range >=1.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 1000, meaning cycles after press_pulse before long_press_pulse; legal range >=1.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 200, meaning auto-repeat period in cycles; legal range >=1.
REQ-004 SHALL have port sysclk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port btn, input, 1, raw asynchronous bouncing push-button.
REQ-007 SHALL have port press_pulse, output, 1, one-cycle pulse per accepted press (and per auto-repeat).
REQ-008 SHALL have port release_pulse, output, 1, one-cycle pulse per accepted release.
REQ-009 SHALL have port long_press_pulse, output, 1, one-cycle pulse when hold reaches LONG_PRESS_CYCLES.
REQ-010 SHALL have port btn_state, output, 1, debounced button level.

Function
REQ-011 SHALL pass btn through a two-flop synchronizer; only the second flop output (sync_btn) feeds downstream logic.
REQ-012 SHALL keep debounce counter deb_cnt, width $clog2(DEBOUNCE_COUNT_THRESHOLD+1); edge with sync_btn==btn_state clears deb_cnt.
REQ-013 SHALL, on edge with sync_btn!=btn_state: if deb_cnt==DEBOUNCE_COUNT_THRESHOLD-1 then toggle btn_state, clear deb_cnt, pulse press or release; else deb_cnt+1.
REQ-014 SHALL assert press_pulse in the cycle after the (THRESHOLD+2)th rising edge, counting the first edge sampling btn high as edge 1, for a bounce-free input; release symmetric.
REQ-015 SHALL restart debounce on any single-cycle glitch back to btn_state (no partial credit).
REQ-016 SHALL implement FSM IDLE, PRESSED, HELD; IDLE->PRESSED on accepted press; PRESSED->HELD when hold_cnt==LONG_PRESS_CYCLES-1; PRESSED/HELD->IDLE on accepted release.
REQ-017 SHALL clear hold_cnt on entering PRESSED and increment it each cycle in PRESSED; long_press_pulse asserts exactly LONG_PRESS_CYCLES cycles after press_pulse.
REQ-018 SHALL give release priority: if accepted release coincides with hold threshold, release_pulse fires, long_press_pulse does not, FSM->IDLE.
REQ-019 SHALL saturate nothing silently: all counters sized via $clog2(param+1) and never wrap while counting.
REQ-020 SHALL never assert press_pulse and release_pulse in the same cycle.

Reset
REQ-021 SHALL, on reset high, immediately clear synchronizer flops, deb_cnt, hold_cnt, rep_cnt, btn_state, all pulse outputs, FSM->IDLE.
REQ-022 SHALL, on reset mid-press, require a full fresh debounce after deassertion before any press_pulse; no release_pulse for interrupted press.
REQ-023 SHALL treat btn already high at reset deassertion as a new press (press_pulse after debounce).

Configuration
REQ-024 SHALL use macro BTN_AUTOREPEAT_EN; defined: in HELD, rep_cnt counts and press_pulse asserts every REPEAT_CYCLES cycles, first repeat REPEAT_CYCLES after long_press_pulse, until release.
REQ-025 SHALL, without BTN_AUTOREPEAT_EN, emit no repeat press_pulse in HELD and omit rep_cnt from RTL.

Verification (THRESHOLD=4, LONG=20, REPEAT=5 unless noted)
REQ-026 SHALL cover clean press: btn 0->1 held 10 cycles -> press_pulse high one cycle at edge 6 after first high sample, btn_state=1.
REQ-027 SHALL cover bounce: btn 1,0,1,1,0,1,1,1,1 -> single press_pulse, only after 4 consecutive high sync samples.
REQ-028 SHALL cover long press: hold 40 cycles -> long_press_pulse exactly 20 cycles after press_pulse; release -> one release_pulse after 6 edges.
REQ-029 SHALL cover auto-repeat (BTN_AUTOREPEAT_EN): hold 40 cycles -> repeat press_pulse at +5, +10, +15 after long_press_pulse; without macro -> none.
REQ-030 SHALL cover release at threshold edge coinciding with hold_cnt==19 -> release_pulse, no long_press_pulse, FSM IDLE.
REQ-031 SHALL cover reset mid-press (hold_cnt=10) -> all outputs 0 immediately; btn still high -> press_pulse 6 edges after deassertion.
